// File: rtl/mouse_ps2_pkg.sv
// Shared PS/2 mouse constants: host commands, device responses, IDs,
// the knock sequence that unlocks scroll-wheel mode, and FSM encodings.
package mouse_ps2_pkg;

  localparam logic [7:0] CMD_RESET        = 8'hFF;
  localparam logic [7:0] CMD_SET_DEFAULTS = 8'hF6;
  localparam logic [7:0] CMD_DISABLE      = 8'hF5;
  localparam logic [7:0] CMD_ENABLE       = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE     = 8'hF3;
  localparam logic [7:0] CMD_GET_ID       = 8'hF2;

  localparam logic [7:0] RESP_ACK    = 8'hFA;
  localparam logic [7:0] RESP_RESEND = 8'hFE;
  localparam logic [7:0] RESP_BAT_OK = 8'hAA;

  localparam logic [7:0] ID_STANDARD = 8'h00;
  localparam logic [7:0] ID_INTELLI  = 8'h03;

  localparam logic [7:0] KNOCK_FIRST  = 8'hC8;
  localparam logic [7:0] KNOCK_SECOND = 8'h64;
  localparam logic [7:0] KNOCK_THIRD  = 8'h50;

  localparam logic [7:0] DEFAULT_RATE = 8'h64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_RESP = 3'd1,
    WAIT_SENT = 3'd2,
    RATE_ARG  = 3'd3,
    BAT_WAIT  = 3'd4,
    PKT_SEND  = 3'd5,
    PKT_WAIT  = 3'd6
  } state_t;

  // What to do once the byte currently on the wire has been sent.
  typedef enum logic [2:0] {
    FOLLOW_NONE       = 3'd0,
    FOLLOW_BAT        = 3'd1,
    FOLLOW_ID_STD     = 3'd2,
    FOLLOW_ID_INTELLI = 3'd3,
    FOLLOW_RATE       = 3'd4,
    FOLLOW_KNOCK      = 3'd5
  } follow_t;

endpackage

// File: rtl/mouse_knock_detect.sv
// Three-deep history of accepted sample rates; flags the C8,64,50
// knock that switches the mouse into scroll-wheel mode.
module mouse_knock_detect
  import mouse_ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic [7:0] rate,
  output logic       match
);

  // Entry 0 is the newest rate, entry 2 the oldest.
  logic [2:0][7:0] hist_q;
  logic [2:0][7:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clear) begin
      hist_d = '0;
    end else if (push) begin
      hist_d = {hist_q[1], hist_q[0], rate};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign match = (hist_q[2] == KNOCK_FIRST) &&
                 (hist_q[1] == KNOCK_SECOND) &&
                 (hist_q[0] == KNOCK_THIRD);

endmodule

// File: rtl/mouse_device_sm.sv
// PS/2 mouse device-side controller: decodes host commands, runs the
// self-test sequence and streams movement packets over a byte transmitter.
module mouse_device_sm
  import mouse_ps2_pkg::*;
#(
  parameter int BAT_DELAY = 5000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] RX_BYTE,
  input  logic [1:0] RX_ERROR_CODE,
  input  logic       RX_READY,
  output logic       RX_READ_ENABLE,
  output logic       TX_SEND_BYTE,
  output logic [7:0] TX_BYTE,
  input  logic       TX_BYTE_SENT,
  input  logic       MOVE_VALID,
  input  logic [7:0] MOVE_STATUS,
  input  logic [7:0] MOVE_DX,
  input  logic [7:0] MOVE_DY,
  input  logic [7:0] MOVE_DZ,
  output logic       MOVE_ACCEPT,
  output logic       STREAM_EN,
  output logic       INTELLI_MODE,
  output logic [7:0] SAMPLE_RATE
);

  localparam logic [23:0] BAT_LAST = 24'(BAT_DELAY - 1);

  state_t          state_q, state_d;
  follow_t         follow_q, follow_d;
  logic [23:0]     bat_cnt_q, bat_cnt_d;
  logic [3:0][7:0] pkt_q, pkt_d;
  logic [1:0]      pkt_idx_q, pkt_idx_d;
  logic            tx_send_q, tx_send_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            move_accept_q, move_accept_d;
  logic            stream_en_q, stream_en_d;
  logic            intelli_q, intelli_d;
  logic [7:0]      sample_rate_q, sample_rate_d;
  logic            rx_read_en_q, rx_read_en_d;

  logic            knock_clear, knock_push, knock_match, illegal_state;
  logic [1:0]      pkt_last;

  mouse_knock_detect u_knock (
    .clk   (CLK),
    .reset (RESET),
    .clear (knock_clear),
    .push  (knock_push),
    .rate  (RX_BYTE),
    .match (knock_match)
  );

  assign pkt_last = intelli_q ? 2'd3 : 2'd2;

  always_comb begin
    state_d       = state_q;
    follow_d      = follow_q;
    bat_cnt_d     = bat_cnt_q;
    pkt_d         = pkt_q;
    pkt_idx_d     = pkt_idx_q;
    tx_send_d     = 1'b0;
    tx_byte_d     = tx_byte_q;
    move_accept_d = 1'b0;
    stream_en_d   = stream_en_q;
    intelli_d     = intelli_q;
    sample_rate_d = sample_rate_q;
    knock_clear   = 1'b0;
    knock_push    = 1'b0;
    illegal_state = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_READY) begin
          state_d  = SEND_RESP;
          follow_d = FOLLOW_NONE;
          if (RX_ERROR_CODE != 2'b00) begin
            tx_byte_d = RESP_RESEND;
          end else begin
            tx_byte_d = RESP_ACK;
            case (RX_BYTE)
              CMD_RESET, CMD_SET_DEFAULTS: begin
                stream_en_d   = 1'b0;
                intelli_d     = 1'b0;
                sample_rate_d = DEFAULT_RATE;
                knock_clear   = 1'b1;
                if (RX_BYTE == CMD_RESET) follow_d = FOLLOW_BAT;
              end
              CMD_DISABLE:  stream_en_d = 1'b0;
              CMD_ENABLE:   stream_en_d = 1'b1;
              CMD_SET_RATE: follow_d = FOLLOW_RATE;
              CMD_GET_ID:   follow_d = intelli_q ? FOLLOW_ID_INTELLI : FOLLOW_ID_STD;
              default:      tx_byte_d = RESP_RESEND;
            endcase
          end
        end else if (stream_en_q && MOVE_VALID) begin
          pkt_d         = {MOVE_DZ, MOVE_DY, MOVE_DX, MOVE_STATUS | 8'h08};
          pkt_idx_d     = 2'd0;
          move_accept_d = 1'b1;
          state_d       = PKT_SEND;
        end
      end
      SEND_RESP: begin
        tx_send_d = 1'b1;
        state_d   = WAIT_SENT;
      end
      WAIT_SENT: begin
        if (TX_BYTE_SENT) begin
          follow_d = FOLLOW_NONE;
          state_d  = IDLE;
          case (follow_q)
            FOLLOW_BAT: begin
              bat_cnt_d = '0;
              state_d   = BAT_WAIT;
            end
            FOLLOW_ID_STD: begin
              tx_byte_d = ID_STANDARD;
              state_d   = SEND_RESP;
            end
            FOLLOW_ID_INTELLI: begin
              tx_byte_d = ID_INTELLI;
              state_d   = SEND_RESP;
            end
            FOLLOW_RATE:  state_d = RATE_ARG;
            FOLLOW_KNOCK: if (knock_match) intelli_d = 1'b1;
            default:      state_d = IDLE;
          endcase
        end
      end
      RATE_ARG: begin
        if (RX_READY) begin
          state_d  = SEND_RESP;
          follow_d = FOLLOW_NONE;
          if (RX_ERROR_CODE != 2'b00) begin
            tx_byte_d = RESP_RESEND;
          end else begin
            sample_rate_d = RX_BYTE;
            knock_push    = 1'b1;
            tx_byte_d     = RESP_ACK;
            follow_d      = FOLLOW_KNOCK;
          end
        end
      end
      // AA goes out straight from the last count so the gap is exactly BAT_DELAY.
      BAT_WAIT: begin
        if (bat_cnt_q == BAT_LAST) begin
          tx_send_d = 1'b1;
          tx_byte_d = RESP_BAT_OK;
          follow_d  = FOLLOW_ID_STD;
          state_d   = WAIT_SENT;
        end else begin
          bat_cnt_d = bat_cnt_q + 24'd1;
        end
      end
      PKT_SEND: begin
        tx_send_d = 1'b1;
        tx_byte_d = pkt_q[pkt_idx_q];
        state_d   = PKT_WAIT;
      end
      PKT_WAIT: begin
        if (TX_BYTE_SENT) begin
          if (pkt_idx_q == pkt_last) begin
            state_d = IDLE;
          end else begin
            pkt_idx_d = pkt_idx_q + 2'd1;
            state_d   = PKT_SEND;
          end
        end
      end
      default: begin
        illegal_state = 1'b1;
        state_d       = IDLE;
        follow_d      = FOLLOW_NONE;
        bat_cnt_d     = '0;
        pkt_idx_d     = '0;
        tx_byte_d     = '0;
        stream_en_d   = 1'b0;
        intelli_d     = 1'b0;
        sample_rate_d = '0;
      end
    endcase

    rx_read_en_d = !illegal_state && ((state_d == IDLE) || (state_d == RATE_ARG));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      follow_q      <= FOLLOW_NONE;
      bat_cnt_q     <= '0;
      pkt_q         <= '0;
      pkt_idx_q     <= '0;
      tx_send_q     <= 1'b0;
      tx_byte_q     <= '0;
      move_accept_q <= 1'b0;
      stream_en_q   <= 1'b0;
      intelli_q     <= 1'b0;
      sample_rate_q <= DEFAULT_RATE;
      rx_read_en_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      follow_q      <= follow_d;
      bat_cnt_q     <= bat_cnt_d;
      pkt_q         <= pkt_d;
      pkt_idx_q     <= pkt_idx_d;
      tx_send_q     <= tx_send_d;
      tx_byte_q     <= tx_byte_d;
      move_accept_q <= move_accept_d;
      stream_en_q   <= stream_en_d;
      intelli_q     <= intelli_d;
      sample_rate_q <= sample_rate_d;
      rx_read_en_q  <= rx_read_en_d;
    end
  end

  assign RX_READ_ENABLE = rx_read_en_q;
  assign TX_SEND_BYTE   = tx_send_q;
  assign TX_BYTE        = tx_byte_q;
  assign MOVE_ACCEPT    = move_accept_q;
  assign STREAM_EN      = stream_en_q;
  assign INTELLI_MODE   = intelli_q;
  assign SAMPLE_RATE    = sample_rate_q;

endmodule

// File: doc/mouse_device_sm.md
MOUSE_DEVICE_SM -- requirements
Module: mouse_device_sm

Interface
REQ-001 The block SHALL run on one clock, with a synchronous, active-high reset: CLK in 1 (rising edge); RESET in 1.
REQ-002 The block SHALL have parameter BAT_DELAY, default 5000000, giving the self-test delay in CLK cycles.
REQ-003 The block SHALL have the following ports:
 - RX_BYTE  in  8  byte received from host
 - RX_ERROR_CODE  in  2  receiver error, 00 = good
 - RX_READY  in  1  one-cycle pulse, RX_BYTE valid
 - RX_READ_ENABLE  out  1  receiver enable
 - TX_SEND_BYTE  out  1  one-cycle pulse to start a transmit
 - TX_BYTE  out  8  byte to transmit
 - TX_BYTE_SENT  in  1  one-cycle pulse, transmit done
 - MOVE_VALID  in  1  movement report pending
 - MOVE_STATUS / MOVE_DX / MOVE_DY / MOVE_DZ  in  8 each  report fields
 - MOVE_ACCEPT  out  1  one-cycle pulse, report latched
 - STREAM_EN  out  1  data reporting enabled
 - INTELLI_MODE  out  1  4-byte scroll-wheel packets active
 - SAMPLE_RATE  out  8  current sample rate

Function
REQ-004 All outputs SHALL be registered, and every response SHALL follow the transmit handshake in REQ-005.
REQ-005 Transmit handshake:
 - TX_SEND_BYTE SHALL pulse for exactly one cycle.
 - TX_BYTE SHALL stay stable from that pulse until TX_BYTE_SENT.
 - The next TX_SEND_BYTE SHALL occur no earlier than the cycle after TX_BYTE_SENT.
REQ-006 RX_READ_ENABLE SHALL be high only in IDLE and RATE_ARG; RX_READY in any other state SHALL be ignored.
REQ-007 In IDLE, a good byte (error code 00) SHALL be decoded, and TX_SEND_BYTE SHALL be asserted in the second cycle after the RX_READY cycle.
REQ-008 FF (reset) SHALL produce:
 - FA;
 - clear STREAM_EN and INTELLI_MODE, set SAMPLE_RATE=100 (0x64), clear the knock history;
 - wait BAT_DELAY cycles after the FA is sent;
 - then AA, then ID 00.
REQ-009 F4 SHALL send FA and set STREAM_EN; F5 SHALL send FA and clear STREAM_EN.
REQ-010 F6 SHALL send FA and restore the FF defaults, without BAT, AA or ID.
REQ-011 F2 SHALL send FA, then ID 03 if INTELLI_MODE is set, else 00.
REQ-012 F3 SHALL send FA and enter RATE_ARG; the next good byte SHALL be stored in SAMPLE_RATE and acknowledged with FA.
REQ-013 Knock history:
 - the last three accepted rate values SHALL be held as a 3-entry shift history;
 - when the history equals C8, 64, 50 (oldest first), INTELLI_MODE SHALL be set once the final FA is sent;
 - a different sequence SHALL leave INTELLI_MODE unchanged.
REQ-014 Any other command byte, or any byte with a nonzero error code in IDLE or RATE_ARG, SHALL be answered with FE; RATE_ARG SHALL then return to IDLE.
REQ-015 Streaming SHALL start in IDLE when STREAM_EN=1, MOVE_VALID=1 and RX_READY=0 in that cycle; RX_READY has priority.
REQ-016 On streaming start the block SHALL latch all MOVE_* fields and pulse MOVE_ACCEPT in the same cycle.
REQ-017 The packet SHALL be sent as status with bit3 forced to 1, then DX, then DY, then DZ only when INTELLI_MODE=1.
REQ-018 A packet in progress SHALL always complete; host bytes arriving during it are dropped because the receiver is disabled.
REQ-019 The states SHALL be: IDLE, SEND_RESP, WAIT_SENT, RATE_ARG, BAT_WAIT, PKT_SEND, PKT_WAIT. Any illegal state SHALL go to IDLE with all outputs cleared.
REQ-020 The BAT counter SHALL be 24 bits, SHALL count from 0 to BAT_DELAY-1, and SHALL restart from 0 on every FF.

Reset
REQ-021 Reset SHALL clear all outputs to 0, except SAMPLE_RATE, which SHALL reset to 0x64.
REQ-022 Reset SHALL put the state in IDLE with no spontaneous AA, and SHALL empty the knock history.
REQ-023 Reset asserted mid-packet or mid-BAT SHALL abort with no further TX_SEND_BYTE.

Structure
REQ-024 Package mouse_ps2_pkg SHALL hold the command codes (FF F6 F5 F4 F3 F2), the response codes (FA FE AA), the ID codes (00 03), the knock constants and the state encoding.
REQ-025 The knock history and its compare SHALL be a sub-module, mouse_knock_detect; everything else SHALL be flat.

Verification
REQ-026 Reset/self-test: RX FF with BAT_DELAY=16 -> TX FA, then 16 idle cycles after FA is sent, then AA, then 00; STREAM_EN=0, SAMPLE_RATE=0x64.
REQ-027 Knock: F3 C8 F3 64 F3 50 F2 -> FA on every byte, final ID 03, INTELLI_MODE=1; the sequence C8 64 3C instead -> ID 00.
REQ-028 Streaming 3-byte: after F4, MOVE_VALID with status 0x01, dx 0x05, dy 0xFB -> one MOVE_ACCEPT pulse, TX 09 05 FB.
REQ-029 Streaming 4-byte: in INTELLI_MODE with dz 0x01 -> TX 09 05 FB 01; F5 then MOVE_VALID -> no transmit and no MOVE_ACCEPT.
REQ-030 Errors: RX byte with error code 01 -> TX FE; RX 0xAB -> TX FE; RX_READY and MOVE_VALID in the same cycle -> the command is served first.
REQ-031 Mid-operation: RESET asserted during the second packet byte -> all outputs are at reset values next cycle and no further sends occur.
